cluster_finder_seq: RTL and testbench



---
 rtl/cluster_finder_seq.sv | 170 +++++++++++++++++
 tb/tb_cluster_finder_seq.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/cluster_finder_seq.sv
// cluster_finder_seq: multi-cycle S-bit cluster finder.
// Captures one bunch crossing per accepted strobe. It then extracts up to
// MAX_CLUSTERS clusters in ascending address order, FINDS_PER_CYCLE per clock,
// and publishes them with a one-cycle valid pulse, a count and an overflow flag.
// Optional feature: define CLUSTER_FINDER_DROP_CNT_EN to count strobes that
// arrive while busy. Otherwise drop_cnt is tied to zero.
module cluster_finder_seq #(
   parameter  int NUM_VFATS       = 24,
   parameter  int SBITS_PER_VFAT  = 64,
   parameter  int MAX_CLUSTERS    = 8,
   parameter  int FINDS_PER_CYCLE = 2,
   parameter  int CNT_BITS        = 3,
   localparam int NSBITS          = NUM_VFATS * SBITS_PER_VFAT,
   localparam int ADR_BITS        = $clog2(NSBITS),
   localparam int W               = CNT_BITS + ADR_BITS,
   localparam int CW              = $clog2(MAX_CLUSTERS + 1)
) (
   input  logic                      clock4x,
   input  logic                      global_reset,
   input  logic                      sbits_valid,
   input  logic [NSBITS-1:0]         sbits,
   input  logic                      truncate_clusters,
   output logic                      busy,
   output logic                      cluster_valid,
   output logic [MAX_CLUSTERS*W-1:0] clusters,
   output logic [CW-1:0]             cluster_count,
   output logic                      overflow,
   output logic [7:0]                drop_cnt
);

   localparam int unsigned MAXSIZE = 2 ** CNT_BITS;
   localparam int unsigned FPC     = FINDS_PER_CYCLE;
   localparam int unsigned NSEARCH = MAX_CLUSTERS / FINDS_PER_CYCLE;
   localparam int          SCW     = $clog2(NSEARCH + 1);
   localparam int          SW      = (MAX_CLUSTERS > 1) ? $clog2(MAX_CLUSTERS) : 1;
   localparam logic [W-1:0] INVALID = {{CNT_BITS{1'b0}}, {ADR_BITS{1'b1}}};

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      SEARCH  = 2'd1,
      PUBLISH = 2'd2
   } state_t;

   state_t              state, state_nxt;
   logic [NSBITS-1:0]   work_r, work_nxt;
   logic                trunc_r;
   logic [SCW-1:0]      search_cnt_r;
   logic [CW-1:0]       found_r, found_nxt;
   logic [W-1:0]        slot_r   [MAX_CLUSTERS];
   logic [W-1:0]        slot_nxt [MAX_CLUSTERS];

   logic [NSBITS-1:0]   f_w, f_low, f_run, f_win, f_seg, f_sh;
   logic [ADR_BITS-1:0] f_adr;
   int unsigned         f_len, f_idx;
   logic                last_search;

   assign busy        = (state != IDLE);
   assign last_search = (search_cnt_r == SCW'(NSEARCH - 1));

   // State register
   always_ff @(posedge clock4x) begin
      if (global_reset) state <= IDLE;
      else              state <= state_nxt;
   end

   // Next-state logic
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (sbits_valid) state_nxt = SEARCH;
         SEARCH:  if (last_search) state_nxt = PUBLISH;
         PUBLISH: state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Cascaded finds for one search cycle.
   // Isolate the lowest set bit: w & -w. Adding it to w carries through the
   // run, so w & ~(w + low) is exactly the run. A carry past the top bit is
   // dropped, so there is no wrap-around.
   always_comb begin
      f_w       = work_r;
      f_low     = '0;
      f_run     = '0;
      f_win     = '0;
      f_seg     = '0;
      f_sh      = '0;
      f_adr     = '0;
      f_len     = 0;
      f_idx     = 0;
      slot_nxt  = slot_r;
      found_nxt = found_r;
      for (int unsigned j = 0; j < FPC; j++) begin
         f_low = f_w & (~f_w + NSBITS'(1));
         f_run = f_w & ~(f_w + f_low);
         f_win = (f_low << MAXSIZE) - f_low;
         f_seg = f_run & f_win;
         f_adr = '0;
         for (int unsigned i = 0; i < NSBITS; i++)
            if (f_low[i]) f_adr = ADR_BITS'(i);
         f_sh  = f_seg >> f_adr;
         f_len = 0;
         for (int unsigned i = 0; i < MAXSIZE; i++)
            if (f_sh[i]) f_len = f_len + 1;
         // Once the register is empty it stays empty, so filled slots form a prefix.
         f_idx = 32'(search_cnt_r) * FPC + j;
         if (f_w != '0) begin
            slot_nxt[SW'(f_idx)] = {CNT_BITS'(f_len - 1), f_adr};
            found_nxt            = found_nxt + CW'(1);
            f_w                  = f_w & ~(trunc_r ? f_run : f_seg);
         end
      end
      work_nxt = f_w;
   end

   // Capture, search datapath and published outputs
   always_ff @(posedge clock4x) begin
      if (global_reset) begin
         work_r        <= '0;
         trunc_r       <= 1'b0;
         search_cnt_r  <= '0;
         found_r       <= '0;
         for (int unsigned k = 0; k < MAX_CLUSTERS; k++) slot_r[k] <= INVALID;
         clusters      <= {MAX_CLUSTERS{INVALID}};
         cluster_valid <= 1'b0;
         cluster_count <= '0;
         overflow      <= 1'b0;
      end else begin
         cluster_valid <= 1'b0;
         case (state)
            IDLE: begin
               if (sbits_valid) begin
                  work_r       <= sbits;
                  trunc_r      <= truncate_clusters;
                  search_cnt_r <= '0;
                  found_r      <= '0;
                  for (int unsigned k = 0; k < MAX_CLUSTERS; k++) slot_r[k] <= INVALID;
               end
            end
            SEARCH: begin
               work_r       <= work_nxt;
               slot_r       <= slot_nxt;
               found_r      <= found_nxt;
               search_cnt_r <= search_cnt_r + SCW'(1);
               // The publish registers load on the edge into PUBLISH. This
               // makes cluster_valid high during the PUBLISH cycle itself.
               if (last_search) begin
                  for (int unsigned k = 0; k < MAX_CLUSTERS; k++)
                     clusters[k*W +: W] <= slot_nxt[k];
                  cluster_valid <= 1'b1;
                  cluster_count <= found_nxt;
                  overflow      <= |work_nxt;
               end
            end
            default: ;
         endcase
      end
   end

`ifdef CLUSTER_FINDER_DROP_CNT_EN
   // Saturating count of strobes ignored while busy
   always_ff @(posedge clock4x) begin
      if (global_reset)                                  drop_cnt <= '0;
      else if (sbits_valid && busy && (drop_cnt != 8'hFF)) drop_cnt <= drop_cnt + 8'd1;
   end
`else
   assign drop_cnt = '0;
`endif

endmodule

// File: tb/tb_cluster_finder_seq.sv
// Directed self-checking bench for cluster_finder_seq (default parameters).
module tb_cluster_finder_seq;

   localparam int NUM_VFATS       = 24;
   localparam int SBITS_PER_VFAT  = 64;
   localparam int MAX_CLUSTERS    = 8;
   localparam int FINDS_PER_CYCLE = 2;
   localparam int CNT_BITS        = 3;
   localparam int NSBITS          = NUM_VFATS * SBITS_PER_VFAT;
   localparam int ADR_BITS        = 11;
   localparam int W               = CNT_BITS + ADR_BITS;
   localparam int CW              = 4;
   localparam int NSEARCH         = MAX_CLUSTERS / FINDS_PER_CYCLE;
   localparam logic [W-1:0] INV   = 14'h07FF;
`ifdef CLUSTER_FINDER_DROP_CNT_EN
   localparam int EXP_DROPS = 4;
`else
   localparam int EXP_DROPS = 0;
`endif

   logic                      clock4x;
   logic                      global_reset;
   logic                      sbits_valid;
   logic [NSBITS-1:0]         sbits;
   logic                      truncate_clusters;
   logic                      busy;
   logic                      cluster_valid;
   logic [MAX_CLUSTERS*W-1:0] clusters;
   logic [CW-1:0]             cluster_count;
   logic                      overflow;
   logic [7:0]                drop_cnt;

   int num_checks = 0;
   int num_errors = 0;

   logic [W-1:0] exp_slot [MAX_CLUSTERS];
   int           exp_n;
   logic         exp_ovf;
   logic [NSBITS-1:0] v;
   int           pulses;

   cluster_finder_seq #(
      .NUM_VFATS       (NUM_VFATS),
      .SBITS_PER_VFAT  (SBITS_PER_VFAT),
      .MAX_CLUSTERS    (MAX_CLUSTERS),
      .FINDS_PER_CYCLE (FINDS_PER_CYCLE),
      .CNT_BITS        (CNT_BITS)
   ) dut (
      .clock4x           (clock4x),
      .global_reset      (global_reset),
      .sbits_valid       (sbits_valid),
      .sbits             (sbits),
      .truncate_clusters (truncate_clusters),
      .busy              (busy),
      .cluster_valid     (cluster_valid),
      .clusters          (clusters),
      .cluster_count     (cluster_count),
      .overflow          (overflow),
      .drop_cnt          (drop_cnt)
   );

   initial clock4x = 1'b0;
   always #5 clock4x = ~clock4x;

   initial begin
      #1ms;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      num_checks++;
      if (obs !== exp) begin
         num_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic clear_exp();
      for (int k = 0; k < MAX_CLUSTERS; k++) exp_slot[k] = INV;
      exp_n   = 0;
      exp_ovf = 1'b0;
   endtask

   task automatic add_exp(input int cnt, input int adr);
      exp_slot[exp_n] = {CNT_BITS'(cnt), ADR_BITS'(adr)};
      exp_n++;
   endtask

   task automatic check_outputs(input string tag);
      for (int k = 0; k < MAX_CLUSTERS; k++)
         check($sformatf("%s_slot%0d", tag, k), 64'(clusters[k*W +: W]), 64'(exp_slot[k]));
      check({tag, "_count"}, 64'(cluster_count), 64'(exp_n));
      check({tag, "_ovf"}, 64'(overflow), 64'(exp_ovf));
   endtask

   // Strobe one event and check busy/valid cycle by cycle.
   // Publish must land in cycle NSEARCH+1.
   task automatic run_event(input string tag, input logic [NSBITS-1:0] vec, input logic t);
      @(negedge clock4x);
      sbits = vec; truncate_clusters = t; sbits_valid = 1'b1;
      @(negedge clock4x);
      sbits_valid = 1'b0; sbits = '0; truncate_clusters = 1'b0;
      for (int c = 1; c <= NSEARCH + 1; c++) begin
         check($sformatf("%s_busy_c%0d", tag, c), 64'(busy), 64'd1);
         check($sformatf("%s_valid_c%0d", tag, c), 64'(cluster_valid),
               (c == NSEARCH + 1) ? 64'd1 : 64'd0);
         if (c <= NSEARCH) @(negedge clock4x);
      end
      check_outputs(tag);
      @(negedge clock4x);
      check({tag, "_busy_after"}, 64'(busy), 64'd0);
      check({tag, "_valid_after"}, 64'(cluster_valid), 64'd0);
      check_outputs({tag, "_hold"});
   endtask

   initial begin
      global_reset = 1'b1; sbits_valid = 1'b0; sbits = '0; truncate_clusters = 1'b0;
      @(negedge clock4x);
      @(negedge clock4x);
      clear_exp();
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_valid", 64'(cluster_valid), 64'd0);
      check("rst_drop", 64'(drop_cnt), 64'd0);
      check_outputs("rst");
      global_reset = 1'b0;

      // Two-strip cluster
      clear_exp(); add_exp(1, 2);
      v = '0; v[2] = 1'b1; v[3] = 1'b1;
      run_event("pair", v, 1'b0);

      // Alternating strips: eight singletons, strips left over
      clear_exp();
      for (int i = 0; i < 8; i++) add_exp(0, 2 * i + 1);
      exp_ovf = 1'b1;
      v = '0; v[35:0] = 36'hAAAAAAAAA;
      run_event("alt", v, 1'b0);

      // Reset in search cycle 2 discards the capture
      @(negedge clock4x);
      v = '0; v[2] = 1'b1;
      sbits = v; sbits_valid = 1'b1;
      @(negedge clock4x);
      sbits_valid = 1'b0;
      @(negedge clock4x);
      global_reset = 1'b1;
      @(negedge clock4x);
      global_reset = 1'b0;
      clear_exp();
      check("midrst_busy", 64'(busy), 64'd0);
      check("midrst_valid", 64'(cluster_valid), 64'd0);
      check_outputs("midrst");
      pulses = 0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clock4x);
         if (cluster_valid) pulses++;
      end
      check("midrst_pulses", 64'(pulses), 64'd0);

      clear_exp(); add_exp(1, 2);
      v = '0; v[2] = 1'b1; v[3] = 1'b1;
      run_event("fresh", v, 1'b0);

      // Long run, not truncated: remainder becomes a second cluster
      clear_exp(); add_exp(7, 100); add_exp(3, 108);
      v = '0; for (int i = 100; i < 112; i++) v[i] = 1'b1;
      run_event("run_notr", v, 1'b0);

      // Long run, truncated
      clear_exp(); add_exp(7, 100);
      run_event("run_tr", v, 1'b1);

      // Run across a VFAT boundary, truncated
      clear_exp(); add_exp(7, 60);
      v = '0; for (int i = 60; i < 70; i++) v[i] = 1'b1;
      run_event("vfat_x", v, 1'b1);

      // Top strip alone
      clear_exp(); add_exp(0, 1535);
      v = '0; v[1535] = 1'b1;
      run_event("top", v, 1'b0);

      // Run ending at the last strip, no wrap-around
      clear_exp(); add_exp(5, 1530);
      v = '0; for (int i = 1530; i < 1536; i++) v[i] = 1'b1;
      run_event("top_run", v, 1'b0);

      // Empty event still publishes, nothing found
      clear_exp();
      run_event("empty", '0, 1'b0);

      // Reset and strobe together: reset wins
      @(negedge clock4x);
      v = '0; v[5] = 1'b1;
      sbits = v; sbits_valid = 1'b1; global_reset = 1'b1;
      @(negedge clock4x);
      sbits_valid = 1'b0; global_reset = 1'b0;
      check("rstv_busy", 64'(busy), 64'd0);
      pulses = 0;
      for (int i = 0; i < 7; i++) begin
         @(negedge clock4x);
         if (cluster_valid) pulses++;
      end
      check("rstv_pulses", 64'(pulses), 64'd0);

      // Strobe held for cycles 0..4: one capture, four ignored strobes
      clear_exp(); add_exp(1, 2);
      v = '0; v[2] = 1'b1; v[3] = 1'b1;
      @(negedge clock4x);
      sbits = v; sbits_valid = 1'b1;
      pulses = 0;
      for (int i = 1; i <= 11; i++) begin
         @(negedge clock4x);
         if (i == 5) begin
            sbits_valid = 1'b0;
            check("hold_valid_c5", 64'(cluster_valid), 64'd1);
            check_outputs("hold");
         end
         if (cluster_valid) pulses++;
      end
      check("hold_pulses", 64'(pulses), 64'd1);
      check("hold_drop", 64'(drop_cnt), 64'(EXP_DROPS));

      $display("Simulation finished: %0d checks, %0d errors", num_checks, num_errors);
      $finish;
   end

endmodule
